// File: rtl/aes_block_ctrl.sv
// Control FSM for the AES HWPE: fetches, encrypts/decrypts and stores a run of blocks.
// Optional watchdog and ERR state are built when AES_CTRL_TIMEOUT_EN is defined.
module aes_block_ctrl #(
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_W          = 32,
    parameter int BLK_W           = 16,
    parameter int TIMEOUT_W       = 12
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clear_i,
    input  logic                               start_i,
    input  logic [ADDR_W-1:0]                  src_base_i,
    input  logic [ADDR_W-1:0]                  dst_base_i,
    input  logic [BLK_W-1:0]                   num_blocks_i,
    input  logic                               mode_i,
    output logic                               src_req_start_o,
    input  logic                               src_ready_start_i,
    input  logic                               src_done_i,
    output logic [ADDR_W-1:0]                  src_addr_o,
    output logic                               dst_req_start_o,
    input  logic                               dst_ready_start_i,
    input  logic                               dst_done_i,
    output logic [ADDR_W-1:0]                  dst_addr_o,
    output logic                               eng_clear_o,
    output logic                               eng_start_o,
    output logic                               eng_mode_o,
    input  logic                               eng_done_i,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_idx_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
);

    localparam int WIDX_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_BLOCK - 1);

    generate
        if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0
            || TIMEOUT_W < 2) begin : g_bad_params
            $error("aes_block_ctrl: invalid parameter set");
        end
    endgenerate

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_FETCH_REQ,
        ST_FETCH_WAIT,
        ST_ENGINE,
        ST_STORE_REQ,
        ST_STORE_WAIT,
        ST_NEXT,
        ST_DONE
`ifdef AES_CTRL_TIMEOUT_EN
        , ST_ERR
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_src_base;
    logic [ADDR_W-1:0]   r_dst_base;
    logic [BLK_W-1:0]    r_num_blocks;
    logic [BLK_W-1:0]    r_blk_idx;
    logic [WIDX_W-1:0]   r_word_idx;
    logic                r_mode;
    logic                r_eng_started;
    logic [BLK_W-1:0]    w_blk_inc;
    logic [ADDR_W-1:0]   w_word_off;

    assign w_blk_inc = r_blk_idx + BLK_W'(1);

    // Power-of-two block size makes blk*WPB + word a plain concatenation.
    assign w_word_off = ADDR_W'({r_blk_idx, r_word_idx, 2'b00});
    assign src_addr_o = r_src_base + w_word_off;
    assign dst_addr_o = r_dst_base + w_word_off;
    assign word_idx_o = r_word_idx;
    assign eng_mode_o = r_mode;

`ifdef AES_CTRL_TIMEOUT_EN
    // Trip one count early so ERR is entered on the edge the counter would hit all-ones.
    localparam logic [TIMEOUT_W-1:0] WDOG_TRIP = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] r_wdog;
    logic                 w_watch;

    assign w_watch = (r_state == ST_FETCH_WAIT) || (r_state == ST_STORE_WAIT)
                  || (r_state == ST_ENGINE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= '0;
        end else if (w_state_next != r_state) begin
            r_wdog <= '0;
        end else if (w_watch) begin
            r_wdog <= r_wdog + TIMEOUT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (start_i) w_state_next = (num_blocks_i == '0) ? ST_DONE : ST_START;
            ST_START:      w_state_next = ST_FETCH_REQ;
            ST_FETCH_REQ:  if (src_ready_start_i) w_state_next = ST_FETCH_WAIT;
            ST_FETCH_WAIT: if (src_done_i)
                               w_state_next = (r_word_idx == LAST_WORD) ? ST_ENGINE : ST_FETCH_REQ;
            ST_ENGINE:     if (eng_done_i) w_state_next = ST_STORE_REQ;
            ST_STORE_REQ:  if (dst_ready_start_i) w_state_next = ST_STORE_WAIT;
            ST_STORE_WAIT: if (dst_done_i)
                               w_state_next = (r_word_idx == LAST_WORD) ? ST_NEXT : ST_STORE_REQ;
            ST_NEXT:       w_state_next = (w_blk_inc == r_num_blocks) ? ST_DONE : ST_FETCH_REQ;
            ST_DONE:       w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
`ifdef AES_CTRL_TIMEOUT_EN
        if (w_watch && (r_wdog == WDOG_TRIP) && (w_state_next == r_state))
            w_state_next = ST_ERR;
`endif
        if (clear_i)
            w_state_next = ST_IDLE;
    end

    always_comb begin
        src_req_start_o = 1'b0;
        dst_req_start_o = 1'b0;
        eng_clear_o     = 1'b0;
        eng_start_o     = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        err_o           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                eng_clear_o = 1'b1;
                busy_o      = 1'b0;
            end
            ST_FETCH_REQ: src_req_start_o = 1'b1;
            ST_STORE_REQ: dst_req_start_o = 1'b1;
            ST_ENGINE:    eng_start_o     = ~r_eng_started;
            ST_DONE:      done_o          = 1'b1;
`ifdef AES_CTRL_TIMEOUT_EN
            ST_ERR: begin
                err_o       = 1'b1;
                eng_clear_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src_base    <= '0;
            r_dst_base    <= '0;
            r_num_blocks  <= '0;
            r_blk_idx     <= '0;
            r_word_idx    <= '0;
            r_mode        <= 1'b0;
            r_eng_started <= 1'b0;
        end else if (clear_i) begin
            r_blk_idx     <= '0;
            r_word_idx    <= '0;
            r_eng_started <= 1'b0;
        end else begin
            // Remembers that the start pulse already went out during this ENGINE visit.
            r_eng_started <= (r_state == ST_ENGINE);
            case (r_state)
                ST_IDLE: if (start_i) begin
                    r_src_base   <= src_base_i;
                    r_dst_base   <= dst_base_i;
                    r_num_blocks <= num_blocks_i;
                    r_mode       <= mode_i;
                    r_blk_idx    <= '0;
                    r_word_idx   <= '0;
                end
                ST_FETCH_WAIT: if (src_done_i)
                    r_word_idx <= (r_word_idx == LAST_WORD) ? '0 : r_word_idx + WIDX_W'(1);
                ST_STORE_WAIT: if (dst_done_i)
                    r_word_idx <= (r_word_idx == LAST_WORD) ? '0 : r_word_idx + WIDX_W'(1);
                ST_NEXT: r_blk_idx <= w_blk_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Directed bench for aes_block_ctrl: table of jobs with streamer/engine models,
// plus hand sequences for reset, abort, clear-vs-start and the optional watchdog.
module tb_aes_block_ctrl;

    logic        clk;
    logic        reset_n;
    logic        clear_i;
    logic        start_i;
    logic [31:0] src_base_i;
    logic [31:0] dst_base_i;
    logic [15:0] num_blocks_i;
    logic        mode_i;
    logic        src_req_start_o;
    logic        src_ready_start_i;
    logic        src_done_i;
    logic [31:0] src_addr_o;
    logic        dst_req_start_o;
    logic        dst_ready_start_i;
    logic        dst_done_i;
    logic [31:0] dst_addr_o;
    logic        eng_clear_o;
    logic        eng_start_o;
    logic        eng_mode_o;
    logic        eng_done_i;
    logic [1:0]  word_idx_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    aes_block_ctrl #(
        .WORDS_PER_BLOCK(4),
        .ADDR_W         (32),
        .BLK_W          (16),
        .TIMEOUT_W      (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .src_base_i       (src_base_i),
        .dst_base_i       (dst_base_i),
        .num_blocks_i     (num_blocks_i),
        .mode_i           (mode_i),
        .src_req_start_o  (src_req_start_o),
        .src_ready_start_i(src_ready_start_i),
        .src_done_i       (src_done_i),
        .src_addr_o       (src_addr_o),
        .dst_req_start_o  (dst_req_start_o),
        .dst_ready_start_i(dst_ready_start_i),
        .dst_done_i       (dst_done_i),
        .dst_addr_o       (dst_addr_o),
        .eng_clear_o      (eng_clear_o),
        .eng_start_o      (eng_start_o),
        .eng_mode_o       (eng_mode_o),
        .eng_done_i       (eng_done_i),
        .word_idx_o       (word_idx_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] nblk;
        logic        mode;
        int          eng_lat;        // ENGINE cycles, eng_done in the last one
        int          src_rdy_wait;   // cycles src_ready held low per request
        int          dst_done_wait;  // extra cycles before dst_done per word
        int          exp_done_cyc;   // edges after the start edge at which done_o is seen
        int          exp_words;
        int          exp_starts;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clear_i = 1'b0; start_i = 1'b0;
        src_ready_start_i = 1'b0; src_done_i = 1'b0;
        dst_ready_start_i = 1'b0; dst_done_i = 1'b0;
        eng_done_i = 1'b0;
    endtask

    // Runs one job with reactive streamer/engine models; clr_at_start>0 aborts
    // with clear_i on the first cycle of that engine start.
    task automatic run_job(input int id, input vec_t v, input int clr_at_start);
        int  cyc, limit, fetch_cnt, store_cnt, starts, done_cnt, done_at, eng_cnt;
        int  s_rdy_cnt, d_done_cnt, clr_cyc;
        bit  s_pend, d_pend, eng_busy;
        fetch_cnt = 0; store_cnt = 0; starts = 0; done_cnt = 0; done_at = -1;
        eng_cnt = 0; s_rdy_cnt = 0; d_done_cnt = 0; clr_cyc = -1;
        s_pend = 0; d_pend = 0; eng_busy = 0;
        limit = (clr_at_start > 0) ? 400 : v.exp_done_cyc + 3;
        @(negedge clk);
        idle_inputs();
        src_base_i = v.src; dst_base_i = v.dst; num_blocks_i = v.nblk; mode_i = v.mode;
        start_i = 1'b1;
        @(posedge clk);
        cyc = 1;
        while (cyc <= limit) begin
            @(negedge clk);
            idle_inputs();
            // Scrambled job inputs and a stray start must not disturb the running job.
            src_base_i = 32'hDEAD_0000; dst_base_i = 32'hBEEF_0000;
            num_blocks_i = 16'd7; mode_i = ~v.mode;
            start_i = (cyc == 5);
            if (done_o) begin done_cnt++; done_at = cyc; end
            if (eng_start_o) begin
                starts++;
                check("eng_mode", 32'(eng_mode_o), 32'(v.mode));
                eng_busy = 1; eng_cnt = 1;
            end else if (eng_busy) begin
                eng_cnt++;
            end
            if (eng_busy && eng_cnt == v.eng_lat) begin eng_done_i = 1'b1; eng_busy = 0; end
            if (clr_at_start > 0 && eng_start_o && starts == clr_at_start) begin
                clear_i = 1'b1; clr_cyc = cyc; eng_busy = 0; eng_done_i = 1'b0;
            end
            src_done_i = eng_start_o;
            if (s_pend) begin
                src_done_i = 1'b1; s_pend = 0; fetch_cnt++;
            end else if (src_req_start_o) begin
                check("src_addr", src_addr_o, v.src + 32'(fetch_cnt * 4));
                check("src_word_idx", 32'(word_idx_o), 32'(fetch_cnt % 4));
                if (s_rdy_cnt >= v.src_rdy_wait) begin
                    src_ready_start_i = 1'b1; s_pend = 1; s_rdy_cnt = 0;
                end else begin
                    s_rdy_cnt++;
                end
            end
            dst_done_i = src_req_start_o;
            if (d_pend) begin
                if (d_done_cnt >= v.dst_done_wait) begin
                    dst_done_i = 1'b1; d_pend = 0; d_done_cnt = 0; store_cnt++;
                end else begin
                    dst_done_i = 1'b0; d_done_cnt++;
                end
            end else if (dst_req_start_o) begin
                check("dst_addr", dst_addr_o, v.dst + 32'(store_cnt * 4));
                check("dst_word_idx", 32'(word_idx_o), 32'(store_cnt % 4));
                dst_ready_start_i = 1'b1; d_pend = 1;
            end
            if (clr_cyc > 0 && cyc == clr_cyc + 1) begin
                check("clear_busy", 32'(busy_o), 32'd0);
                check("clear_eng_clear", 32'(eng_clear_o), 32'd1);
            end
            if (clr_cyc > 0 && cyc == clr_cyc + 12) break;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        idle_inputs();
        if (clr_at_start == 0) begin
            check("done_latency", 32'(done_at), 32'(v.exp_done_cyc));
            check("done_count", 32'(done_cnt), 32'd1);
            check("fetch_count", 32'(fetch_cnt), 32'(v.exp_words));
            check("store_count", 32'(store_cnt), 32'(v.exp_words));
            check("eng_starts", 32'(starts), 32'(v.exp_starts));
            check("idle_busy", 32'(busy_o), 32'd0);
            check("idle_eng_clear", 32'(eng_clear_o), 32'd1);
        end else begin
            check("clear_reached", 32'(clr_cyc > 0), 32'd1);
            check("clear_no_done", 32'(done_cnt), 32'd0);
        end
        $display("job %0d: blocks=%0d fetched=%0d stored=%0d starts=%0d done_at=%0d",
                 id, v.nblk, fetch_cnt, store_cnt, starts, done_at);
    endtask

    vec_t vecs[6];
    vec_t vclr;

    initial begin
        //          src           dst           nblk  mode lat rdy dwt done words starts
        vecs[0] = '{32'h0000_1000, 32'h0000_2000, 16'd1, 1'b0, 5, 0, 0, 24, 4, 1};
        vecs[1] = '{32'h0000_1000, 32'h0000_2000, 16'd3, 1'b1, 3, 0, 0, 62, 12, 3};
        vecs[2] = '{32'h0000_1000, 32'h0000_2000, 16'd0, 1'b0, 5, 0, 0, 1, 0, 0};
        vecs[3] = '{32'h0000_1000, 32'h0000_2000, 16'd1, 1'b0, 1, 7, 3, 60, 4, 1};
        vecs[4] = '{32'hFFFF_FFF8, 32'h0000_0010, 16'd1, 1'b1, 2, 0, 0, 21, 4, 1};
        vecs[5] = '{32'h0000_5000, 32'h0000_6000, 16'd2, 1'b1, 4, 2, 1, 68, 8, 2};
        vclr    = '{32'h0000_3000, 32'h0000_4000, 16'd2, 1'b0, 10, 0, 0, 0, 0, 0};

        reset_n = 1'b0;
        src_base_i = '0; dst_base_i = '0; num_blocks_i = '0; mode_i = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_eng_clear", 32'(eng_clear_o), 32'd1);
        check("rst_eng_mode", 32'(eng_mode_o), 32'd0);
        check("rst_src_addr", src_addr_o, 32'd0);
        check("rst_dst_addr", dst_addr_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_src_req", 32'(src_req_start_o), 32'd0);
        check("rst_dst_req", 32'(dst_req_start_o), 32'd0);
        check("rst_eng_start", 32'(eng_start_o), 32'd0);
        check("rst_word_idx", 32'(word_idx_o), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_job(i, vecs[i], 0);

        // Abort in ENGINE of block 1 of 2, then a fresh job must start at block 0.
        run_job(6, vclr, 2);
        run_job(7, vecs[0], 0);

        // clear_i wins over a simultaneous start_i.
        @(negedge clk);
        num_blocks_i = 16'd1; start_i = 1'b1; clear_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("clear_vs_start_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("clear_vs_start_req", 32'(src_req_start_o), 32'd0);
        $display("seq clear_vs_start: busy=%0b", busy_o);

        // Asynchronous reset mid-job drops to IDLE without waiting for an edge.
        @(negedge clk);
        src_base_i = 32'h0000_1000; num_blocks_i = 16'd1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("midjob_busy", 32'(busy_o), 32'd1);
        #2 reset_n = 1'b0;
        #1 check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_word", 32'(word_idx_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        $display("seq async_reset: busy=%0b", busy_o);
        run_job(8, vecs[0], 0);

`ifdef AES_CTRL_TIMEOUT_EN
        begin
            int  k, err_at, dcnt;
            bit  s_pend;
            k = -1; err_at = -1; dcnt = 0; s_pend = 0;
            @(negedge clk);
            idle_inputs();
            src_base_i = 32'h0000_1000; dst_base_i = 32'h0000_2000;
            num_blocks_i = 16'd1; mode_i = 1'b0; start_i = 1'b1;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                start_i = 1'b0;
                src_done_i = s_pend;
                s_pend = src_req_start_o;
                src_ready_start_i = src_req_start_o;
                if (done_o) dcnt++;
                if (eng_start_o) k = 0;
                else if (k >= 0) k++;
                if (err_o) begin err_at = k; break; end
            end
            idle_inputs();
            check("tmo_err_cycle", 32'(err_at), 32'd15);
            check("tmo_err_eng_clear", 32'(eng_clear_o), 32'd1);
            @(negedge clk);
            check("tmo_idle_busy", 32'(busy_o), 32'd0);
            check("tmo_err_pulse", 32'(err_o), 32'd0);
            check("tmo_no_done", 32'(dcnt + 32'(done_o)), 32'd0);
            $display("seq timeout: err_at=%0d", err_at);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
